// File: rtl/fpu_prim_pkg.sv
// fpu_prim_pkg: shared FPU primitive types and constants.
//   sqrt_state_t : sqrt_r2 FSM state (IDLE, CALC, DONE)
//   SQRT_W       : default radicand width
//   sqrt_cnt_w   : iteration counter width for a W-bit radicand
package fpu_prim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    localparam int SQRT_W = 48;

    function automatic int sqrt_cnt_w(input int w);
        return $clog2(w / 2);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one radix-2 restoring square-root iteration (combinational).
// Ports:
//   r      in  W/2+2  partial remainder
//   q      in  W/2    partial root
//   b      in  2      next two radicand bits (MSB first)
//   r_next out W/2+2  updated partial remainder
//   q_next out W/2    updated partial root (new bit shifted in at LSB)
module sqrt_step
    import fpu_prim_pkg::*;
#(
    parameter int W = SQRT_W
) (
    input  logic [W/2+1:0] r,
    input  logic [W/2-1:0] q,
    input  logic [1:0]     b,
    output logic [W/2+1:0] r_next,
    output logic [W/2-1:0] q_next
);
    localparam int H = W / 2;

    logic [H+3:0] w_lhs;
    logic [H+1:0] w_rhs;
    logic [H+1:0] w_diff;
    logic         w_ge;

    // A full-width compare picks the branch, so the difference only needs
    // its low H+2 bits: a non-negative trial result always fits there.
    assign w_lhs  = {r, b};
    assign w_rhs  = {q, 2'b01};
    assign w_ge   = w_lhs >= {2'b00, w_rhs};
    assign w_diff = w_lhs[H+1:0] - w_rhs;
    assign r_next = w_ge ? w_diff : w_lhs[H+1:0];
    assign q_next = {q[H-2:0], w_ge};

endmodule

// File: rtl/sqrt_r2.sv
// sqrt_r2: iterative radix-2 restoring integer square root, one root bit per clock.
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      synchronous active-low reset
//   start  in  1      request, accepted only while ready=1
//   rad    in  W      radicand, captured on the accepted start
//   ready  out 1      can accept start (IDLE or DONE)
//   busy   out 1      iteration in progress (CALC)
//   done   out 1      one-cycle pulse, results valid from this cycle on
//   root   out W/2    floor(sqrt(rad))
//   rem    out W/2+1  rad - root*root
//   exact  out 1      rem == 0
module sqrt_r2
    import fpu_prim_pkg::*;
#(
    parameter int W = SQRT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   rad,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [W/2-1:0] root,
    output logic [W/2:0]   rem,
    output logic           exact
);
    localparam int            H    = W / 2;
    localparam int            CW   = sqrt_cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(H - 1);

    sqrt_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rad;
    logic [H+1:0]  r_prem;
    logic [H-1:0]  r_proot;
    logic [H-1:0]  r_root;
    logic [H:0]    r_rem;
    logic          r_exact;

    logic [H+1:0]  w_r_next;
    logic [H-1:0]  w_q_next;

    sqrt_step #(.W(W)) u_step (
        .r      (r_prem),
        .q      (r_proot),
        .b      (r_rad[W-1:W-2]),
        .r_next (w_r_next),
        .q_next (w_q_next)
    );

    assign ready = (r_state == IDLE) || (r_state == DONE);
    assign busy  = r_state == CALC;
    assign done  = r_state == DONE;
    assign root  = r_root;
    assign rem   = r_rem;
    assign exact = r_exact;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rad   <= '0;
            r_prem  <= '0;
            r_proot <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_exact <= 1'b1;
        end else if (ready && start) begin
            r_state <= CALC;
            r_cnt   <= '0;
            r_rad   <= rad;
            r_prem  <= '0;
            r_proot <= '0;
        end else if (r_state == CALC) begin
            r_rad   <= {r_rad[W-3:0], 2'b00};
            r_prem  <= w_r_next;
            r_proot <= w_q_next;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_state <= DONE;
                r_root  <= w_q_next;
                // The remainder MSB is always zero on completion; the full
                // width still feeds the exact flag.
                r_rem   <= w_r_next[H:0];
                r_exact <= w_r_next == '0;
            end
        end else begin
            r_state <= IDLE;
        end
    end

endmodule
